// File: rtl/ad7357_pkg.sv
// rtl/ad7357_pkg.sv - shared constants, state type and frame-slot helper for the AD7357 interface
package ad7357_pkg;

    localparam int AD7357_DATA_W      = 14;
    localparam int AD7357_FRAME_SCLKS = 16;
    localparam int AD7357_LEAD_ZEROS  = 2;

    // Half-cycle counts are taken before the i_clk edge; the edge with count 2k-1 raises SCLK for the k-th time.
    localparam logic [5:0] AD7357_HC_END = 6'(2 * AD7357_FRAME_SCLKS);
    localparam logic [5:0] AD7357_HC_LZ  = 6'(2 * (AD7357_LEAD_ZEROS - 1) - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        QUIET
    } ad7357_state_e;

    function automatic logic is_data_rise(input logic [5:0] hc);
        logic [5:0] k;
        k = (hc + 6'd1) >> 1;
        return hc[0] && (k >= 6'(AD7357_LEAD_ZEROS))
                     && (k < 6'(AD7357_LEAD_ZEROS + AD7357_DATA_W));
    endfunction

endpackage

// File: rtl/ad7357_shreg.sv
// rtl/ad7357_shreg.sv - per-line MSB-first capture shift register for one ADC data output
module ad7357_shreg
    import ad7357_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_bit,
    output logic [AD7357_DATA_W-1:0] o_data
);

    logic [AD7357_DATA_W-1:0] data_q;
    logic [AD7357_DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (i_en) begin
            data_d = {data_q[AD7357_DATA_W-2:0], i_bit};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_data = data_q;

endmodule

// File: rtl/ad7357if.sv
// rtl/ad7357if.sv - AD7357 master serial interface top; AD7357IF_ZERO_CHECK_EN adds leading-zero check on o_err
module ad7357if
    import ad7357_pkg::*;
#(
    parameter int QUIET_CYCLES = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_acquire,
    output logic                     o_ready,
    output logic [AD7357_DATA_W-1:0] o_sample_a,
    output logic [AD7357_DATA_W-1:0] o_sample_b,
    output logic                     o_if_sclk,
    output logic                     o_if_cs_n,
    input  logic                     i_if_sdata_a,
    input  logic                     i_if_sdata_b
`ifdef AD7357IF_ZERO_CHECK_EN
    ,
    output logic                     o_err
`endif
);

    ad7357_state_e            state_q, state_d;
    logic [5:0]               cnt_q, cnt_d;
    logic                     cs_n_q, cs_n_d;
    logic                     sclk_q, sclk_d;
    logic                     ready_q, ready_d;
    logic [AD7357_DATA_W-1:0] sample_a_q, sample_a_d;
    logic [AD7357_DATA_W-1:0] sample_b_q, sample_b_d;
    logic [AD7357_DATA_W-1:0] shreg_a, shreg_b;
    logic                     shift_en;

    // cnt_q counts SCLK half-cycles in SHIFT and is reused as the quiet-time counter in QUIET.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        ready_d    = ready_q;
        sample_a_d = sample_a_q;
        sample_b_d = sample_b_q;
        shift_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_acquire) begin
                    state_d = SHIFT;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == AD7357_HC_END) begin
                    state_d    = QUIET;
                    cs_n_d     = 1'b1;
                    sclk_d     = 1'b1;
                    sample_a_d = shreg_a;
                    sample_b_d = shreg_b;
                    cnt_d      = '0;
                end else begin
                    sclk_d   = ~sclk_q;
                    cnt_d    = cnt_q + 6'd1;
                    shift_en = is_data_rise(cnt_q);
                end
            end
            QUIET: begin
                if (cnt_q == 6'(QUIET_CYCLES - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            ready_q    <= 1'b1;
            sample_a_q <= '0;
            sample_b_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            ready_q    <= ready_d;
            sample_a_q <= sample_a_d;
            sample_b_q <= sample_b_d;
        end
    end

    ad7357_shreg u_shreg_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (shift_en),
        .i_bit   (i_if_sdata_a),
        .o_data  (shreg_a)
    );

    ad7357_shreg u_shreg_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (shift_en),
        .i_bit   (i_if_sdata_b),
        .o_data  (shreg_b)
    );

`ifdef AD7357IF_ZERO_CHECK_EN
    logic lz_a_q, lz_a_d;
    logic lz_b_q, lz_b_d;
    logic err_q, err_d;

    always_comb begin
        lz_a_d = lz_a_q;
        lz_b_d = lz_b_q;
        err_d  = err_q;
        if (state_q == SHIFT && cnt_q == AD7357_HC_LZ) begin
            lz_a_d = i_if_sdata_a;
            lz_b_d = i_if_sdata_b;
        end
        if (state_q == SHIFT && cnt_q == AD7357_HC_END) begin
            err_d = lz_a_q | lz_b_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lz_a_q <= 1'b0;
            lz_b_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            lz_a_q <= lz_a_d;
            lz_b_q <= lz_b_d;
            err_q  <= err_d;
        end
    end

    assign o_err = err_q;
`endif

    assign o_ready    = ready_q;
    assign o_sample_a = sample_a_q;
    assign o_sample_b = sample_b_q;
    assign o_if_sclk  = sclk_q;
    assign o_if_cs_n  = cs_n_q;

endmodule

// File: tb/tb_ad7357if.sv
// tb/tb_ad7357if.sv - self-checking bench for ad7357if with a behavioural AD7357 data-output model
module tb_ad7357if;

    localparam int QC = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_acquire;
    logic        o_ready;
    logic [13:0] o_sample_a;
    logic [13:0] o_sample_b;
    logic        o_if_sclk;
    logic        o_if_cs_n;
    logic        i_if_sdata_a = 1'b0;
    logic        i_if_sdata_b = 1'b0;
`ifdef AD7357IF_ZERO_CHECK_EN
    logic        o_err;
`endif

    int checks = 0;
    int errors = 0;

    ad7357if #(.QUIET_CYCLES(QC)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_acquire    (i_acquire),
        .o_ready      (o_ready),
        .o_sample_a   (o_sample_a),
        .o_sample_b   (o_sample_b),
        .o_if_sclk    (o_if_sclk),
        .o_if_cs_n    (o_if_cs_n),
        .i_if_sdata_a (i_if_sdata_a),
        .i_if_sdata_b (i_if_sdata_b)
`ifdef AD7357IF_ZERO_CHECK_EN
        ,
        .o_err        (o_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    // ADC model: 16-bit frame {lead0, lead1, data[13:0]}; MSB appears at CS fall, next bit after each SCLK fall.
    logic [13:0] adc_a, adc_b;
    logic        inj_a, inj_b;
    logic [15:0] frame_a, frame_b;
    int          bit_idx;
    int          cs_falls = 0;
    int          sclk_rises = 0;
    int          gap = 0;
    int          last_gap = 0;

    always @(negedge o_if_cs_n) begin
        frame_a      = {1'b0, inj_a, adc_a};
        frame_b      = {1'b0, inj_b, adc_b};
        bit_idx      = 15;
        i_if_sdata_a = frame_a[15];
        i_if_sdata_b = frame_b[15];
        cs_falls     = cs_falls + 1;
    end

    always @(negedge o_if_sclk) begin
        if (!o_if_cs_n) begin
            bit_idx = bit_idx - 1;
            i_if_sdata_a = (bit_idx >= 0) ? frame_a[bit_idx] : 1'b0;
            i_if_sdata_b = (bit_idx >= 0) ? frame_b[bit_idx] : 1'b0;
        end
    end

    always @(posedge o_if_sclk) begin
        if (!o_if_cs_n) sclk_rises = sclk_rises + 1;
    end

    always @(negedge i_clk) begin
        if (o_if_cs_n === 1'b1) begin
            gap = gap + 1;
        end else begin
            if (gap > 0) last_gap = gap;
            gap = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame starting at the next rising edge (E0); returns at the negedge after E33+QC.
    task automatic run_frame(input logic [13:0] a, input logic [13:0] b,
                             input logic ia, input logic ib,
                             input bit poke, input bit hold);
        int  falls0;
        int  rises0;
        bit  bad_cs;
        bit  bad_sclk;
        adc_a  = a;
        adc_b  = b;
        inj_a  = ia;
        inj_b  = ib;
        falls0 = cs_falls;
        rises0 = sclk_rises;
        bad_cs   = 1'b0;
        bad_sclk = 1'b0;
        chk("ready_before", o_ready, 1);
        i_acquire = 1'b1;
        @(negedge i_clk);
        chk("cs_low_e0", o_if_cs_n, 0);
        chk("ready_low_e0", o_ready, 0);
        for (int n = 1; n <= 32; n++) begin
            @(negedge i_clk);
            if (o_if_cs_n !== 1'b0) bad_cs = 1'b1;
            if (o_if_sclk !== ((n % 2) == 0)) bad_sclk = 1'b1;
            if (o_ready !== 1'b0) bad_cs = 1'b1;
            if (!hold && n == 1) i_acquire = 1'b0;
            if (poke && n == 9) i_acquire = 1'b1;
            if (poke && !hold && n == 10) i_acquire = 1'b0;
        end
        chk("cs_ready_during_shift", bad_cs, 0);
        chk("sclk_pattern", bad_sclk, 0);
        chk("sclk_rise_count", sclk_rises - rises0, 16);
        @(negedge i_clk);
        chk("cs_high_e33", o_if_cs_n, 1);
        chk("sclk_high_e33", o_if_sclk, 1);
        chk("sample_a", o_sample_a, a);
        chk("sample_b", o_sample_b, b);
        chk("ready_low_e33", o_ready, 0);
`ifdef AD7357IF_ZERO_CHECK_EN
        chk("err_e33", o_err, ia | ib);
`endif
        for (int q = 1; q <= QC; q++) begin
            @(negedge i_clk);
            chk("ready_quiet", o_ready, (q == QC));
            chk("cs_quiet", o_if_cs_n, 1);
        end
        chk("one_cs_pulse", cs_falls - falls0, 1);
    endtask

    initial begin
        logic [13:0] ra, rb;
        logic        rib;
        int          falls_keep;
        i_rst_n   = 1'b0;
        i_acquire = 1'b0;
        adc_a = '0; adc_b = '0; inj_a = 1'b0; inj_b = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_cs_n", o_if_cs_n, 1);
        chk("rst_sclk", o_if_sclk, 1);
        chk("rst_ready", o_ready, 1);
        chk("rst_sample_a", o_sample_a, 0);
        chk("rst_sample_b", o_sample_b, 0);
`ifdef AD7357IF_ZERO_CHECK_EN
        chk("rst_err", o_err, 0);
`endif
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        run_frame(14'h2345, 14'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(14'h3FFF, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(14'h0000, 14'h3FFF, 1'b0, 1'b0, 1'b0, 1'b0);

        ra = 14'($urandom); rb = 14'($urandom);
        run_frame(ra, rb, 1'b0, 1'b0, 1'b1, 1'b0);
        falls_keep = cs_falls;
        repeat (4) begin
            @(negedge i_clk);
            chk("idle_cs_high", o_if_cs_n, 1);
        end
        chk("busy_no_extra_frame", cs_falls, falls_keep);
        chk("hold_sample_a", o_sample_a, ra);
        chk("hold_sample_b", o_sample_b, rb);

        run_frame(14'($urandom), 14'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(14'($urandom), 14'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(14'($urandom), 14'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cs_gap_back_to_back", last_gap, QC + 1);

        for (int i = 0; i < 4; i++) begin
            ra  = 14'($urandom);
            rb  = 14'($urandom);
            rib = 1'($urandom);
            run_frame(ra, rb, 1'b0, rib, 1'b0, 1'b0);
        end

        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("idle_rst_sample_a", o_sample_a, 0);
        chk("idle_rst_ready", o_ready, 1);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        run_frame(14'h1A5C, 14'h05A3, 1'b0, 1'b0, 1'b0, 1'b0);
        adc_a = 14'h3C3C; adc_b = 14'h0F0F;
        i_acquire = 1'b1;
        @(negedge i_clk);
        i_acquire = 1'b0;
        repeat (19) @(negedge i_clk);
        @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        chk("midrst_cs_n", o_if_cs_n, 1);
        chk("midrst_sclk", o_if_sclk, 1);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_sample_a", o_sample_a, 0);
        chk("midrst_sample_b", o_sample_b, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        run_frame(14'h2B6D, 14'h1C71, 1'b0, 1'b0, 1'b0, 1'b0);

        run_frame(14'h0123, 14'h3210, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frame(14'h0456, 14'h0654, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(14'h3ABC, 14'h0CBA, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
